// File: rtl/switch_debouncer_pkg.sv
// Board-level constants for the slide-switch front end and the debounce
// threshold derived from them.
package switch_debouncer_pkg;

    localparam int unsigned SW_WIDTH    = 10;
    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEBOUNCE_MS = 20;

    function automatic int unsigned debounce_cycles(input int unsigned clk_hz,
                                                    input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = debounce_cycles(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// Single switch bit: synchronizer chain, persistence counter, stable level flop
// and one-cycle change pulse.
module debounce_bit #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_changed,
    output logic accept
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    // accept is the next-cycle value of sw_changed; the top registers its
    // OR-reduction so any_changed lines up with the per-bit pulses.
    always_comb begin
        accept = (sync != sw_stable) && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            sw_stable  <= 1'b0;
            cnt        <= '0;
            sw_changed <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sw_raw};
            sw_changed <= accept;
            if (sync == sw_stable) begin
                cnt <= '0;
            end else if (accept) begin
                sw_stable <= sync;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw slide-switch pins into a clean level vector with per-bit
// change pulses for the switch PIO.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed
);

    logic [WIDTH-1:0] accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .sw_raw    (sw_raw[i]),
            .sw_stable (sw_stable[i]),
            .sw_changed(sw_changed[i]),
            .accept    (accept[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_changed <= 1'b0;
        end else begin
            any_changed <= |accept;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and random checks of switch_debouncer against a sliding-window model.
module tb_switch_debouncer;

    localparam int W = 10;
    localparam int S = 2;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_changed;
    logic         any_changed;

    int checks   = 0;
    int failures = 0;

    // Model: raw is delayed S edges to form the sync sample; a level is
    // accepted once the last D sync samples all disagree with it.
    logic [W-1:0] m_pipe[S];
    logic [W-1:0] m_hist[D];
    logic [W-1:0] m_stable;
    logic [W-1:0] m_changed;
    logic         m_any;

    int pulse_cnt[W];
    int any_cnt;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_stable  (sw_stable),
        .sw_changed (sw_changed),
        .any_changed(any_changed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) m_pipe[i] = '0;
        for (int i = 0; i < D; i++) m_hist[i] = '0;
        m_stable  = '0;
        m_changed = '0;
        m_any     = 1'b0;
    endtask

    task automatic model_edge();
        logic all_diff;
        for (int i = D - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_pipe[S-1];
        m_changed = '0;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int i = 0; i < D; i++)
                if (m_hist[i][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_stable[b]  = ~m_stable[b];
                m_changed[b] = 1'b1;
            end
        end
        m_any = |m_changed;
        for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = sw_raw;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("stable", 32'(sw_stable), 32'(m_stable));
        chk("changed", 32'(sw_changed), 32'(m_changed));
        chk("any", 32'(any_changed), 32'(m_any));
        for (int b = 0; b < W; b++) pulse_cnt[b] += int'(sw_changed[b]);
        any_cnt += int'(any_changed);
    endtask

    task automatic wait_stable(input logic [W-1:0] target, input int budget, output int edges);
        edges = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (sw_stable === target) begin
                edges = k;
                break;
            end
        end
    endtask

    // Reset raised mid-cycle, held across one rising edge, released at negedge.
    task automatic pulse_reset(input logic [W-1:0] raw);
        #2;
        sw_raw = raw;
        reset  = 1'b1;
        model_reset();
        #1;
        chk("rst_stable", 32'(sw_stable), 32'h0);
        chk("rst_changed", 32'(sw_changed), 32'h0);
        chk("rst_any", 32'(any_changed), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int pulse_total();
        int t = 0;
        for (int b = 0; b < W; b++) t += pulse_cnt[b];
        return t;
    endfunction

    initial begin
        int edges;
        int p0, p9, a0, tot0;
        logic [W-1:0] mask;
        int hold;

        for (int b = 0; b < W; b++) pulse_cnt[b] = 0;
        any_cnt = 0;
        sw_raw  = '0;
        reset   = 1'b1;
        model_reset();
        #1;
        chk("init_stable", 32'(sw_stable), 32'h0);
        chk("init_any", 32'(any_changed), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();

        // Reset with all switches high; release still high -> accepted as changes.
        pulse_reset(10'h3FF);
        wait_stable(10'h3FF, 30, edges);
        chk("post_reset_latency", 32'(edges), 32'd10);
        chk("post_reset_pulse", 32'(sw_changed), 32'h3FF);
        chk("post_reset_any", 32'(any_changed), 32'h1);
        step();
        chk("post_reset_pulse_end", 32'(sw_changed), 32'h0);

        // Clean rising edge on bit 0.
        sw_raw = '0;
        wait_stable(10'h000, 30, edges);
        chk("fall_all_latency", 32'(edges), 32'd10);
        tot0   = pulse_total();
        sw_raw = 10'h001;
        wait_stable(10'h001, 30, edges);
        chk("clean_latency", 32'(edges), 32'd10);
        chk("clean_pulse", 32'(sw_changed), 32'h001);
        repeat (3) step();
        chk("clean_pulse_count", 32'(pulse_total() - tot0), 32'd1);

        // Bounce on bit 3 shorter than the threshold is rejected.
        tot0 = pulse_total();
        sw_raw[3] = 1'b1; repeat (5) step();
        sw_raw[3] = 1'b0; repeat (2) step();
        sw_raw[3] = 1'b1; repeat (5) step();
        sw_raw[3] = 1'b0; repeat (20) step();
        chk("bounce_stable", 32'(sw_stable), 32'h001);
        chk("bounce_no_pulse", 32'(pulse_total() - tot0), 32'd0);

        // Bounce then settle on bit 5: counting restarts after the low glitch.
        sw_raw[5] = 1'b1; repeat (6) step();
        sw_raw[5] = 1'b0; step();
        chk("settle_not_early", 32'(sw_stable[5]), 32'h0);
        sw_raw[5] = 1'b1;
        wait_stable(10'h021, 30, edges);
        chk("settle_latency", 32'(edges), 32'd10);

        // Simultaneous change on several bits.
        sw_raw = '0;
        wait_stable(10'h000, 30, edges);
        tot0   = pulse_total();
        a0     = any_cnt;
        sw_raw = 10'h2A5;
        wait_stable(10'h2A5, 30, edges);
        chk("simul_latency", 32'(edges), 32'd10);
        chk("simul_pulse", 32'(sw_changed), 32'h2A5);
        repeat (3) step();
        chk("simul_pulse_count", 32'(pulse_total() - tot0), 32'd5);
        chk("simul_any_count", 32'(any_cnt - a0), 32'd1);

        // Reset in the middle of a debounce on bit 9.
        sw_raw = '0;
        wait_stable(10'h000, 30, edges);
        p9     = pulse_cnt[9];
        sw_raw = 10'h200;
        repeat (4) step();
        pulse_reset(10'h200);
        chk("midrst_no_pulse", 32'(pulse_cnt[9] - p9), 32'd0);
        wait_stable(10'h200, 30, edges);
        chk("midrst_latency", 32'(edges), 32'd10);
        chk("midrst_pulse", 32'(sw_changed), 32'h200);

        // Random bouncing on all bits against the model.
        p0 = pulse_total();
        for (int seg = 0; seg < 250; seg++) begin
            mask   = W'($urandom) & W'($urandom);
            sw_raw = sw_raw ^ mask;
            hold   = int'($urandom_range(1, 12));
            repeat (hold) step();
        end
        repeat (20) step();
        chk("random_some_pulses", 32'(pulse_total() > p0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
